vec_engine: RTL

VEC_ENGINE -- requirements
Module: vec_engine

---
 rtl/vec_engine_pkg.sv | 34 +++
 rtl/vec_engine_if.sv | 37 +++
 rtl/vec_alu.sv | 37 +++
 rtl/vec_engine.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/vec_engine_pkg.sv
// vec_engine_pkg: shared types and default sizing for the vector engine.
//   op_e     - command opcodes (values 6..7 are illegal)
//   state_e  - control FSM states
//   DEF_*    - default parameter values used by the engine, ALU and interface
package vec_engine_pkg;

    localparam int DEF_NUM_VREGS = 4;
    localparam int DEF_VLEN      = 512;
    localparam int DEF_ELEM_W    = 32;
    localparam int DEF_MEM_DEPTH = 512;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'd0,
        OP_STORE = 3'd1,
        OP_VADD  = 3'd2,
        OP_VSUB  = 3'd3,
        OP_VMUL  = 3'd4,
        OP_VAND  = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_ISSUE,
        S_LD_DRAIN,
        S_ST,
        S_EXEC,
        S_DONE
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= 3'(OP_VAND);
    endfunction

endpackage

// File: rtl/vec_engine_if.sv
// vec_engine_if: command, status and memory bus of the vector engine.
//   cmd_*  - command handshake and operands (host -> engine, ready back)
//   done/err/busy - completion / illegal-opcode pulses and busy level
//   mem_*  - single-port word memory; mem_rdata valid 1 cycle after mem_addr
// Modports: slave = engine side, master = host/memory side.
interface vec_engine_if
    import vec_engine_pkg::*;
#(
    parameter int RW     = $clog2(DEF_NUM_VREGS),
    parameter int ADDR_W = $clog2(DEF_MEM_DEPTH),
    parameter int ELEM_W = DEF_ELEM_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [RW-1:0]     cmd_vd;
    logic [RW-1:0]     cmd_vs1;
    logic [RW-1:0]     cmd_vs2;
    logic [ADDR_W-1:0] cmd_addr;
    logic              done;
    logic              err;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [ELEM_W-1:0] mem_wdata;
    logic [ELEM_W-1:0] mem_rdata;

    modport slave (
        input  cmd_valid, cmd_op, cmd_vd, cmd_vs1, cmd_vs2, cmd_addr, mem_rdata,
        output cmd_ready, done, err, busy, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output cmd_valid, cmd_op, cmd_vd, cmd_vs1, cmd_vs2, cmd_addr, mem_rdata,
        input  cmd_ready, done, err, busy, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/vec_alu.sv
// vec_alu: combinational element-wise ALU over a full vector register.
//   op - opcode (VADD/VSUB/VMUL/VAND; anything else yields 0)
//   a  - first source vector, b - second source vector
//   y  - result; every element is computed modulo 2^ELEM_W, VMUL unsigned low half
module vec_alu
    import vec_engine_pkg::*;
#(
    parameter int VLEN   = DEF_VLEN,
    parameter int ELEM_W = DEF_ELEM_W
) (
    input  logic [2:0]      op,
    input  logic [VLEN-1:0] a,
    input  logic [VLEN-1:0] b,
    output logic [VLEN-1:0] y
);
    localparam int WPV = VLEN / ELEM_W;

    for (genvar i = 0; i < WPV; i++) begin : g_elem
        logic [ELEM_W-1:0] ea, eb, ey;

        assign ea = a[i*ELEM_W +: ELEM_W];
        assign eb = b[i*ELEM_W +: ELEM_W];

        always_comb begin
            ey = '0;
            case (op)
                OP_VADD: ey = ea + eb;
                OP_VSUB: ey = ea - eb;
                OP_VMUL: ey = ea * eb;
                OP_VAND: ey = ea & eb;
                default: ey = '0;
            endcase
        end

        assign y[i*ELEM_W +: ELEM_W] = ey;
    end
endmodule

// File: rtl/vec_engine.sv
// vec_engine: small vector unit with NUM_VREGS registers of VLEN bits.
//   clk, rst - single clock, synchronous active-high reset
//   bus      - vec_engine_if.slave: command handshake, done/err/busy, memory port
//   rd_sel   - debug register select
//   rd_data  - combinational contents of vreg[rd_sel]
// LOAD streams WPV words in (addresses issued one cycle ahead of capture),
// STORE streams WPV words out, ALU ops write a whole register in one cycle.
module vec_engine
    import vec_engine_pkg::*;
#(
    parameter  int NUM_VREGS = DEF_NUM_VREGS,
    parameter  int VLEN      = DEF_VLEN,
    parameter  int ELEM_W    = DEF_ELEM_W,
    parameter  int MEM_DEPTH = DEF_MEM_DEPTH,
    localparam int RW        = $clog2(NUM_VREGS),
    localparam int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    vec_engine_if.slave     bus,
    input  logic [RW-1:0]   rd_sel,
    output logic [VLEN-1:0] rd_data
);
    localparam int WPV = VLEN / ELEM_W;
    localparam int IW  = $clog2(WPV);
    localparam int CW  = IW + 1;

    state_e                        state_q, state_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic                          err_q, err_d;
    logic [NUM_VREGS-1:0][VLEN-1:0] vreg_q, vreg_d;
    logic [2:0]                    op_q;
    logic [RW-1:0]                 vd_q, vs1_q, vs2_q;
    logic [ADDR_W-1:0]             base_q;

    logic                          accept;
    logic [VLEN-1:0]               alu_y;
    logic [IW-1:0]                 ld_idx;
    logic [ADDR_W:0]               addr_sum, addr_wrap;

    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign bus.cmd_ready = (state_q == S_IDLE) && !rst;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.err       = err_q;
    assign bus.mem_we    = (state_q == S_ST);
    assign rd_data       = vreg_q[rd_sel];

    // Address = base + counter, wrapped at MEM_DEPTH (which need not be a power of 2).
    assign addr_sum = {1'b0, base_q} + (ADDR_W+1)'(cnt_q);
    always_comb begin
        addr_wrap = addr_sum;
        if (addr_sum >= (ADDR_W+1)'(MEM_DEPTH))
            addr_wrap = addr_sum - (ADDR_W+1)'(MEM_DEPTH);
    end
    assign bus.mem_addr  = addr_wrap[ADDR_W-1:0];
    assign bus.mem_wdata = vreg_q[vs1_q][cnt_q[IW-1:0]*ELEM_W +: ELEM_W];

    // Read data lags its address by one cycle, so the element being captured
    // is counter-1. In LD_DRAIN the counter is WPV, whose low bits minus one
    // land on the last element.
    assign ld_idx = IW'(cnt_q - CW'(1));

    vec_alu #(
        .VLEN   (VLEN),
        .ELEM_W (ELEM_W)
    ) u_alu (
        .op (op_q),
        .a  (vreg_q[vs1_q]),
        .b  (vreg_q[vs2_q]),
        .y  (alu_y)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        vreg_d  = vreg_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    // Illegal opcodes are swallowed here: err next cycle, no state change.
                    if (!op_legal(bus.cmd_op)) begin
                        err_d = 1'b1;
                    end else begin
                        case (op_e'(bus.cmd_op))
                            OP_LOAD:  state_d = S_LD_ISSUE;
                            OP_STORE: state_d = S_ST;
                            default:  state_d = S_EXEC;
                        endcase
                    end
                end
            end
            S_LD_ISSUE: begin
                if (cnt_q != '0)
                    vreg_d[vd_q][ld_idx*ELEM_W +: ELEM_W] = bus.mem_rdata;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WPV-1))
                    state_d = S_LD_DRAIN;
            end
            S_LD_DRAIN: begin
                vreg_d[vd_q][ld_idx*ELEM_W +: ELEM_W] = bus.mem_rdata;
                state_d = S_DONE;
            end
            S_ST: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WPV-1))
                    state_d = S_DONE;
            end
            S_EXEC: begin
                // ALU reads registered sources, so vd aliasing a source is safe.
                vreg_d[vd_q] = alu_y;
                state_d      = S_DONE;
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            vreg_q  <= '0;
            op_q    <= '0;
            vd_q    <= '0;
            vs1_q   <= '0;
            vs2_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            vreg_q  <= vreg_d;
            if (accept) begin
                op_q   <= bus.cmd_op;
                vd_q   <= bus.cmd_vd;
                vs1_q  <= bus.cmd_vs1;
                vs2_q  <= bus.cmd_vs2;
                base_q <= bus.cmd_addr;
            end
        end
    end
endmodule
